// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO with registered pop data, replace-top/bypass on
// simultaneous push+pop, occupancy count, almost-full, sticky error flags, sync clear.
// Ports: clk_i, reset_ni (async active-low), clear_i, push_i/din_i, pop_i,
// dout_o/dout_valid_o (one cycle after an accepted pop), count_o, empty_o, full_o,
// almost_full_o, overflow_o, underflow_o.
// Optional macro LIFO_STACK_PEEK_EN adds peek_o/peek_valid_o (top entry, no pop).
module lifo_stack #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     dout_valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     almost_full_o,
    output logic                     overflow_o,
`ifdef LIFO_STACK_PEEK_EN
    output logic                     underflow_o,
    output logic [WIDTH-1:0]         peek_o,
    output logic                     peek_valid_o
`else
    output logic                     underflow_o
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    top_idx, wr_idx;
    logic             do_push, do_pop, swap, bypass;

    assign empty_o       = count_o == '0;
    assign full_o        = count_o == CW'(DEPTH);
    assign almost_full_o = count_o >= CW'(AF_THRESH);
    assign top_idx       = AW'(count_o - 1'b1);
    assign wr_idx        = AW'(count_o);
    assign do_push       = push_i & ~pop_i & ~full_o;
    assign do_pop        = pop_i & ~push_i & ~empty_o;
    // push+pop on a non-empty stack replaces the top; on empty it bypasses din_i
    assign swap          = push_i & pop_i & ~empty_o;
    assign bypass        = push_i & pop_i & empty_o;

    always_ff @(posedge clk_i) begin
        if (!clear_i && (do_push || swap))
            mem[swap ? top_idx : wr_idx] <= din_i;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_o      <= '0;
            dout_o       <= '0;
            dout_valid_o <= 1'b0;
            overflow_o   <= 1'b0;
            underflow_o  <= 1'b0;
        end else if (clear_i) begin
            count_o      <= '0;
            dout_valid_o <= 1'b0;
            overflow_o   <= 1'b0;
            underflow_o  <= 1'b0;
        end else begin
            count_o      <= do_push ? count_o + 1'b1 : do_pop ? count_o - 1'b1 : count_o;
            dout_o       <= (do_pop || swap) ? mem[top_idx] : bypass ? din_i : dout_o;
            dout_valid_o <= do_pop | swap | bypass;
            overflow_o   <= overflow_o | (push_i & ~pop_i & full_o);
            underflow_o  <= underflow_o | (pop_i & ~push_i & empty_o);
        end
    end

`ifdef LIFO_STACK_PEEK_EN
    assign peek_o       = empty_o ? '0 : mem[top_idx];
    assign peek_valid_o = ~empty_o;
`endif
endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: table-driven check of lifo_stack (DEPTH=4, AF_THRESH=3) with a pop-data scoreboard.
module tb_lifo_stack;
    logic       clk_i = 1'b0;
    logic       reset_ni, clear_i, push_i, pop_i;
    logic [7:0] din_i, dout_o;
    logic       dout_valid_o, empty_o, full_o, almost_full_o, overflow_o, underflow_o;
    logic [2:0] count_o;
`ifdef LIFO_STACK_PEEK_EN
    logic [7:0] peek_o;
    logic       peek_valid_o;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        bit clr, psh, pop;
        logic [7:0] din;
        int cnt;
        bit e, f, af, ov, un, dv;
        logic [7:0] dout;
    } vec_t;
    vec_t vt [$];

    lifo_stack #(.DEPTH(4), .WIDTH(8), .AF_THRESH(3)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .clear_i(clear_i), .push_i(push_i),
        .din_i(din_i), .pop_i(pop_i), .dout_o(dout_o), .dout_valid_o(dout_valid_o),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
        .almost_full_o(almost_full_o), .overflow_o(overflow_o),
`ifdef LIFO_STACK_PEEK_EN
        .underflow_o(underflow_o), .peek_o(peek_o), .peek_valid_o(peek_valid_o)
`else
        .underflow_o(underflow_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t v(bit c, bit p, bit o, logic [7:0] d, int cnt,
                               bit e, bit f, bit af, bit ov, bit un, bit dv, logic [7:0] dq);
        vec_t r;
        r.clr = c; r.psh = p; r.pop = o; r.din = d; r.cnt = cnt;
        r.e = e; r.f = f; r.af = af; r.ov = ov; r.un = un; r.dv = dv; r.dout = dq;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(bit c, bit p, bit o, logic [7:0] d);
        @(negedge clk_i);
        clear_i = c; push_i = p; pop_i = o; din_i = d;
        @(posedge clk_i);
        #1;
        clear_i = 0; push_i = 0; pop_i = 0;
    endtask

    task automatic sb_check();
        if (dout_valid_o) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: dout 0x%0h with nothing expected", dout_o);
            end else chk("sb_dout", dout_o, exp_q.pop_front());
        end
    endtask

    initial begin
        reset_ni = 0; clear_i = 0; push_i = 0; pop_i = 0; din_i = 0;
        //         clr psh pop din   cnt e f af ov un dv dout
        vt.push_back(v(0,1,0,8'h11, 1,0,0,0,0,0,0,8'h00));
        vt.push_back(v(0,1,0,8'h22, 2,0,0,0,0,0,0,8'h00));
        vt.push_back(v(0,1,0,8'h33, 3,0,0,1,0,0,0,8'h00));
        vt.push_back(v(0,0,1,8'h00, 2,0,0,0,0,0,1,8'h33));
        vt.push_back(v(0,0,1,8'h00, 1,0,0,0,0,0,1,8'h22));
        vt.push_back(v(0,0,1,8'h00, 0,1,0,0,0,0,1,8'h11));
        vt.push_back(v(0,1,0,8'hA0, 1,0,0,0,0,0,0,8'h11));
        vt.push_back(v(0,1,0,8'hA1, 2,0,0,0,0,0,0,8'h11));
        vt.push_back(v(0,1,0,8'hA2, 3,0,0,1,0,0,0,8'h11));
        vt.push_back(v(0,1,0,8'hA3, 4,0,1,1,0,0,0,8'h11));
        vt.push_back(v(0,1,0,8'hFF, 4,0,1,1,1,0,0,8'h11));
        vt.push_back(v(0,0,0,8'h00, 4,0,1,1,1,0,0,8'h11));
        vt.push_back(v(0,0,1,8'h00, 3,0,0,1,1,0,1,8'hA3));
        vt.push_back(v(0,0,1,8'h00, 2,0,0,0,1,0,1,8'hA2));
        vt.push_back(v(0,0,1,8'h00, 1,0,0,0,1,0,1,8'hA1));
        vt.push_back(v(0,0,1,8'h00, 0,1,0,0,1,0,1,8'hA0));
        vt.push_back(v(0,0,1,8'h00, 0,1,0,0,1,1,0,8'hA0));
        vt.push_back(v(1,0,0,8'h00, 0,1,0,0,0,0,0,8'hA0));
        vt.push_back(v(0,1,0,8'h05, 1,0,0,0,0,0,0,8'hA0));
        vt.push_back(v(0,1,1,8'h06, 1,0,0,0,0,0,1,8'h05));
        vt.push_back(v(0,0,1,8'h00, 0,1,0,0,0,0,1,8'h06));
        vt.push_back(v(0,1,1,8'h77, 0,1,0,0,0,0,1,8'h77));
        vt.push_back(v(0,1,0,8'h01, 1,0,0,0,0,0,0,8'h77));
        vt.push_back(v(0,1,0,8'h02, 2,0,0,0,0,0,0,8'h77));
        vt.push_back(v(0,1,0,8'h03, 3,0,0,1,0,0,0,8'h77));
        vt.push_back(v(0,1,0,8'h04, 4,0,1,1,0,0,0,8'h77));
        vt.push_back(v(0,1,1,8'h09, 4,0,1,1,0,0,1,8'h04));
        vt.push_back(v(0,0,1,8'h00, 3,0,0,1,0,0,1,8'h09));
        vt.push_back(v(1,1,1,8'h55, 0,1,0,0,0,0,0,8'h09));

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_count", 32'(count_o), 0);
        chk("rst_empty", 32'(empty_o), 1);
        chk("rst_dv", 32'(dout_valid_o), 0);
        chk("rst_dout", 32'(dout_o), 0);
        chk("rst_ov", 32'(overflow_o), 0);
        chk("rst_un", 32'(underflow_o), 0);
        @(negedge clk_i);
        reset_ni = 1;

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].dv) exp_q.push_back(vt[i].dout);
            drive(vt[i].clr, vt[i].psh, vt[i].pop, vt[i].din);
            chk($sformatf("v%0d_count", i), 32'(count_o), 32'(vt[i].cnt));
            chk($sformatf("v%0d_empty", i), 32'(empty_o), 32'(vt[i].e));
            chk($sformatf("v%0d_full", i), 32'(full_o), 32'(vt[i].f));
            chk($sformatf("v%0d_afull", i), 32'(almost_full_o), 32'(vt[i].af));
            chk($sformatf("v%0d_ovf", i), 32'(overflow_o), 32'(vt[i].ov));
            chk($sformatf("v%0d_unf", i), 32'(underflow_o), 32'(vt[i].un));
            chk($sformatf("v%0d_dv", i), 32'(dout_valid_o), 32'(vt[i].dv));
            chk($sformatf("v%0d_dout", i), 32'(dout_o), 32'(vt[i].dout));
            sb_check();
        end
        chk("sb_drained", 32'(exp_q.size()), 0);

        // async reset between edges: set underflow, hold 2 entries, pop so dv=1, then drop reset
        drive(0, 0, 1, 8'h00);
        drive(0, 1, 0, 8'hAA);
        drive(0, 1, 0, 8'hBB);
        drive(0, 0, 1, 8'h00);
        chk("pre_arst_dv", 32'(dout_valid_o), 1);
        chk("pre_arst_dout", 32'(dout_o), 32'h BB);
        chk("pre_arst_un", 32'(underflow_o), 1);
        #1 reset_ni = 0;
        #1;
        chk("arst_count", 32'(count_o), 0);
        chk("arst_dv", 32'(dout_valid_o), 0);
        chk("arst_dout", 32'(dout_o), 0);
        chk("arst_un", 32'(underflow_o), 0);
        chk("arst_ov", 32'(overflow_o), 0);
        chk("arst_empty", 32'(empty_o), 1);
        @(negedge clk_i);
        reset_ni = 1;

`ifdef LIFO_STACK_PEEK_EN
        drive(0, 1, 0, 8'h3C);
        chk("peek_data", 32'(peek_o), 32'h3C);
        chk("peek_valid", 32'(peek_valid_o), 1);
        chk("peek_nopop", 32'(dout_valid_o), 0);
        drive(0, 0, 1, 8'h00);
        chk("peek_pop_dout", 32'(dout_o), 32'h3C);
        chk("peek_empty_data", 32'(peek_o), 0);
        chk("peek_empty_valid", 32'(peek_valid_o), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised stack with data-valid output, the next generation of the team's FILO register.
- Adds:
  - simultaneous push/pop (replace-top and empty bypass)
  - occupancy count and almost-full threshold
  - sticky overflow/underflow error flags
  - synchronous clear
- Used as a return-address or operand stack in datapath blocks; sits between a producer and consumer in one clock domain.

Parameters:
- DEPTH, 8, number of entries; must be >= 2 (power of two not required).
- WIDTH, 8, data bits per entry.
- AF_THRESH, DEPTH-1, almost_full_o asserts when count >= AF_THRESH; legal range 1..DEPTH.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_ni  input  1  reset; asynchronous, active-low.
- clear_i  input  1  synchronous flush: empties the stack and clears error flags.
- push_i  input  1  push din_i onto the top of the stack.
- din_i  input  WIDTH  push data.
- pop_i  input  1  pop the top entry to dout_o.
- dout_o  output  WIDTH  registered popped data.
- dout_valid_o  output  1  one-cycle strobe: dout_o updated this cycle.
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- empty_o  output  1  count_o == 0.
- full_o  output  1  count_o == DEPTH.
- almost_full_o  output  1  count_o >= AF_THRESH.
- overflow_o  output  1  sticky: a push was dropped.
- underflow_o  output  1  sticky: a pop hit an empty stack.

Behaviour:
- Reset (reset_ni low, asynchronous):
  - count, dout_o, dout_valid_o, overflow_o and underflow_o all go to 0.
  - Storage array is not reset.
  - Deassertion is taken synchronously by the integrator.
- Storage: entries 0..count-1; top is entry count-1; push writes entry count.
- empty_o, full_o and almost_full_o are combinational decodes of the count register (no extra latency).
- dout_valid_o defaults to 0 every cycle; it is 1 only in the cycle after an accepted pop.
- Pop latency is 1 cycle: dout_o and dout_valid_o are registered on the edge that samples pop_i. dout_o holds its value until the next accepted pop.
- Priority is clear_i first, then the push/pop case below, evaluated on the pre-edge count.
- clear_i = 1:
  - count <= 0; overflow_o and underflow_o <= 0; dout_valid_o <= 0.
  - push_i and pop_i are ignored that cycle.
- Push only:
  - Not full: mem[count] <= din_i; count <= count+1.
  - Full: data dropped, count unchanged, overflow_o <= 1. There is no wrap-around and no overwrite of old entries.
- Pop only:
  - Not empty: dout_o <= mem[count-1]; dout_valid_o <= 1; count <= count-1.
  - Empty: dout_o unchanged, dout_valid_o <= 0, underflow_o <= 1.
- Push and pop together:
  - Not empty (including full): dout_o <= mem[count-1]; dout_valid_o <= 1; mem[count-1] <= din_i; count unchanged. No overflow is flagged.
  - Empty (bypass): dout_o <= din_i; dout_valid_o <= 1; count stays 0. No underflow is flagged.
- Neither push nor pop: no state change.
- Sticky flags:
  - Once set, a flag stays 1 until clear_i or reset.
  - Setting is level-independent: repeated events keep the flag at 1.
- Count arithmetic: count is $clog2(DEPTH)+1 bits wide, unsigned, and saturates by construction (never exceeds DEPTH, never below 0).

Optional Feature:
- Macro: LIFO_STACK_PEEK_EN.
- Defined:
  - Adds output peek_o [WIDTH] = mem[count-1], combinational from registered state.
  - peek_o = 0 when empty.
  - Adds output peek_valid_o = ~empty_o.
  - Lets consumers inspect the top without popping.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- All tests use DEPTH=4, WIDTH=8, AF_THRESH=3.
- Reset then push 0x11, 0x22, 0x33 on consecutive cycles -> count_o = 3, almost_full_o = 1, full_o = 0. Then pop x3 -> dout_o = 0x33, 0x22, 0x11, each with dout_valid_o = 1 one cycle after its pop. Ends with empty_o = 1.
- Fill with 0xA0..0xA3, push 0xFF -> count_o stays 4, overflow_o = 1 and stays 1. Pop x4 -> 0xA3, 0xA2, 0xA1, 0xA0 (0xFF never appears).
- Pop on empty -> underflow_o = 1, dout_valid_o = 0, dout_o unchanged. Assert clear_i one cycle -> both flags 0, count_o = 0.
- Push 0x05, then push+pop with din 0x06 -> dout_o = 0x05 valid, count_o = 1. Pop -> 0x06. Then push+pop on empty with din 0x77 -> dout_o = 0x77 valid, count_o = 0, no flags.
- Push 2 entries, pull reset_ni low mid-cycle (between edges) -> count_o, dout_valid_o and flags go to 0 immediately without waiting for a clock edge.
- With LIFO_STACK_PEEK_EN: push 0x3C -> peek_o = 0x3C, peek_valid_o = 1 with no pop. After pop -> peek_valid_o = 0, peek_o = 0.
